// File: rtl/wiscsc15_pkg.sv
// Shared constants for the WISC-SC15 core: opcode map, fetch FSM states and
// the default reset PC.
package wiscsc15_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Fetch FSM encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [15:0] WISCSC15_RESET_PC = 16'h0000;

endpackage

// File: rtl/wiscsc15_fetch_fifo.sv
// Synchronous prefetch FIFO with flush. Read data is the registered head
// entry, so a word pushed in cycle N is visible at the head in N+1.
module wiscsc15_fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch unit: single-outstanding imem requests,
// prefetch FIFO towards decode, redirect flush and HLT stop.
// Optional macro WISCSC15_FETCH_PERF_EN adds perf_fetched/perf_stall counters.
module wiscsc15_fetch
    import wiscsc15_pkg::*;
#(
    parameter int               ADDR_W     = 16,
    parameter int               INSTR_W    = 16,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(WISCSC15_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [3:0]         opcode,
    output logic               halted
`ifdef WISCSC15_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);
    localparam int FW = INSTR_W + ADDR_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;     // address of the outstanding request
    logic              drop;       // an orphaned response is still in flight
    logic              accept;
    logic              push;
    logic              pop;
    logic [FW-1:0]     head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;

    // Redirect withdraws the request so memory never sees an address we
    // would immediately discard.
    assign imem_req  = !rst && !redirect_valid && (state == ST_FETCH) && !drop &&
                       (fifo_count < CW'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign push      = !rst && !redirect_valid && (state == ST_WAIT) && imem_rvalid;
    assign pop       = !redirect_valid && instr_valid && instr_ready;

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : head[FW-1 -: INSTR_W];
    assign instr_pc    = fifo_empty ? '0 : head[ADDR_W-1:0];
    assign opcode      = instr[INSTR_W-1 -: 4];
    assign halted      = (state == ST_HALT);

    wiscsc15_fetch_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({imem_rdata, req_pc}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Fetch FSM, PC and stale-response bookkeeping; redirect overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            drop     <= 1'b0;
        end else if (redirect_valid) begin
            state    <= ST_FETCH;
            fetch_pc <= redirect_pc;
            // A response still owed (WAIT, or already orphaned) must be eaten
            // unless it lands in this very cycle.
            drop     <= ((state == ST_WAIT) || drop) && !imem_rvalid;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (drop && imem_rvalid) drop <= 1'b0;
                    if (accept) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid)
                        state <= (imem_rdata[INSTR_W-1 -: 4] == OP_HLT) ? ST_HALT : ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

`ifdef WISCSC15_FETCH_PERF_EN
    // Words delivered into the buffer and decode-starved cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (!instr_valid && !halted) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
